ram_arbiter_ctrl: RTL and testbench
===================================

RAM_ARBITER_CTRL -- requirements
Module: ram_arbiter_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum cycles spent in WAIT for ram_tx_valid (legal range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  2  per-requester transaction request; bit i = requester i.
REQ-005 req_wr  in  2  per-requester opcode: 1 = write, 0 = read.
REQ-006 req_addr  in  16  requester i address at [8i+7:8i].
REQ-007 req_wdata  in  16  requester i write data at [8i+7:8i].
REQ-008 req_ready  out  2  accept strobe; a transaction transfers when req_valid[i] & req_ready[i].
REQ-009 rsp_valid  out  2  one-hot, one-cycle completion pulse to the owning requester.
REQ-010 rsp_rdata  out  8  read data; qualified by rsp_valid.
REQ-011 rsp_err  out  1  read timeout flag; qualified by rsp_valid.
REQ-012 busy  out  1  high whenever state != IDLE.
REQ-013 ram_din  out  10  RAM command word {cmd[1:0], payload[7:0]}.
REQ-014 ram_rx_valid  out  1  RAM command strobe.
REQ-015 ram_dout  in  8  RAM read data.
REQ-016 ram_tx_valid  in  1  RAM read-data valid.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, WDATA, RCMD, WAIT and RESP.
REQ-018 In IDLE, req_ready SHALL equal the grant vector (combinational from req_valid and last_grant); a grant SHALL latch owner, opcode, address and wdata, update last_grant and go to ADDR.
REQ-019 Arbitration SHALL be round-robin: if one requester is valid, grant it; if both are valid, grant the one not equal to last_grant.
REQ-020 req_ready SHALL be 2'b00 in every state other than IDLE.
REQ-021 ADDR SHALL drive ram_rx_valid=1 and ram_din={2'b00,addr} for a write or {2'b10,addr} for a read, then go to WDATA (write) or RCMD (read).
REQ-022 WDATA SHALL drive ram_rx_valid=1 and ram_din={2'b01,wdata}, then go to RESP.
REQ-023 RCMD SHALL drive ram_rx_valid=1 and ram_din=10'h300, then go to WAIT.
REQ-024 In every other state, ram_rx_valid=0 and ram_din=10'h000.
REQ-025 WAIT SHALL count cycles from 0 on entry; when ram_tx_valid=1, capture ram_dout into rsp_rdata, clear the error flag and go to RESP.
REQ-026 If ram_tx_valid=0 when the count equals TIMEOUT-1, WAIT SHALL set rsp_rdata=8'h00 and the error flag, then go to RESP, so WAIT lasts at most TIMEOUT cycles.
REQ-027 ram_tx_valid SHALL be ignored outside WAIT.
REQ-028 RESP SHALL assert rsp_valid[owner] for exactly one cycle, with rsp_err=1 only on a read timeout; a write SHALL respond with rsp_rdata=8'h00 and rsp_err=0; RESP then goes to IDLE.
REQ-029 rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-030 Latency, with accept in cycle T: a write SHALL reach RESP at T+3; a read against a one-cycle RAM SHALL reach RESP at T+4; the next accept SHALL occur no earlier than T+4 for a write and T+5 for a read.
REQ-031 Changes to req_* inputs after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-032 While rst=1, without waiting for a clock edge: state=IDLE, last_grant=1 (so requester 0 wins first), and all outputs 0 (ram_din=10'h000, rsp_rdata=8'h00, ram_rx_valid=0, req_ready=0 for the duration of reset).
REQ-033 Reset mid-transaction SHALL discard the transaction with no rsp_valid pulse, and SHALL drop ram_rx_valid within the same cycle.

Verification
REQ-034 Write by req0, addr 0x3C, data 0xA5, accepted at T -> ram_din=0x03C at T+1, 0x1A5 at T+2; rsp_valid=2'b01, rsp_err=0 at T+3.
REQ-035 Read by req1, addr 0x3C, after REQ-034, with a behavioural RAM model -> ram_din=0x23C at T+1, 0x300 at T+2; rsp_valid=2'b10, rsp_rdata=0xA5 at T+4.
REQ-036 Both req_valid held high from reset -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-037 ram_tx_valid tied 0, TIMEOUT=8, read -> exactly 8 WAIT cycles, then rsp_valid pulse with rsp_err=1 and rsp_rdata=0x00.
REQ-038 rst pulsed during WAIT -> busy, ram_rx_valid and req_ready drop to 0 immediately, no rsp_valid; after release, req0 wins a simultaneous request.
REQ-039 req0 issues two back-to-back writes -> second accepted at T+4; ram_din sequence is 0x0aa, 0x1dd, 0x0aa', 0x1dd' with no idle-cycle violations.

Source files
------------

// File: rtl/ram_arbiter_ctrl.sv
// ram_arbiter_ctrl: two-requester round-robin front end for a RAM that takes
// 10-bit command words {cmd[1:0], payload[7:0]} and answers reads on a
// separate valid/data pair. One transaction is in flight at a time; the
// requester that issued it gets a single-cycle completion pulse.
//
// Command encoding on ram_din:
//   2'b00 : write address      2'b01 : write data
//   2'b10 : read address       2'b11 : read go (payload 8'h00)
module ram_arbiter_ctrl #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [9:0]  ram_din,
   output logic        ram_rx_valid,
   input  logic [7:0]  ram_dout,
   input  logic        ram_tx_valid
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_RCMD  = 3'd3,
      S_WAIT  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   localparam logic [1:0] CMD_WADDR = 2'b00;
   localparam logic [1:0] CMD_WDATA = 2'b01;
   localparam logic [1:0] CMD_RADDR = 2'b10;
   localparam logic [1:0] CMD_RGO   = 2'b11;

   // Index of the last WAIT cycle; a read still unanswered here times out.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   // Controller state and the latched copy of the accepted transaction.
   state_t      state_q;
   logic        last_grant_q;   // index of the requester granted most recently
   logic        owner_q;        // index of the requester that owns the transaction
   logic        wr_q;
   logic [7:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  wait_cnt_q;

   // Registered outputs.
   logic [1:0]  rsp_valid_q;
   logic [7:0]  rsp_rdata_q;
   logic        rsp_err_q;
   logic [9:0]  ram_din_q;
   logic        ram_rx_valid_q;

   // Per-requester views of the packed request buses.
   logic [7:0]  addr_lane  [2];
   logic [7:0]  wdata_lane [2];

   logic [1:0]  grant;
   logic        grant_idx;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign addr_lane[gi]  = req_addr[8*gi +: 8];
         assign wdata_lane[gi] = req_wdata[8*gi +: 8];
      end
   endgenerate

   // Round-robin pick: a lone requester always wins; on a tie the requester
   // that was not served last time wins.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign grant_idx = grant[1];

   // Ready is only offered while idle, and is forced low for the whole of
   // reset rather than waiting for state to settle.
   assign req_ready    = ((state_q == S_IDLE) && !rst) ? grant : 2'b00;
   assign busy         = (state_q != S_IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;
   assign ram_din      = ram_din_q;
   assign ram_rx_valid = ram_rx_valid_q;

   // Transaction sequencer; outputs are computed one cycle ahead so that they
   // are registered and line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         last_grant_q   <= 1'b1;
         owner_q        <= 1'b0;
         wr_q           <= 1'b0;
         addr_q         <= 8'h00;
         wdata_q        <= 8'h00;
         wait_cnt_q     <= 8'h00;
         rsp_valid_q    <= 2'b00;
         rsp_rdata_q    <= 8'h00;
         rsp_err_q      <= 1'b0;
         ram_din_q      <= 10'h000;
         ram_rx_valid_q <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state below re-asserts them.
         ram_rx_valid_q <= 1'b0;
         ram_din_q      <= 10'h000;
         rsp_valid_q    <= 2'b00;

         case (state_q)
            S_IDLE: begin
               if (grant != 2'b00) begin
                  owner_q        <= grant_idx;
                  wr_q           <= req_wr[grant_idx];
                  addr_q         <= addr_lane[grant_idx];
                  wdata_q        <= wdata_lane[grant_idx];
                  last_grant_q   <= grant_idx;
                  ram_rx_valid_q <= 1'b1;
                  ram_din_q      <= {(req_wr[grant_idx] ? CMD_WADDR : CMD_RADDR),
                                     addr_lane[grant_idx]};
                  state_q        <= S_ADDR;
               end
            end

            S_ADDR: begin
               ram_rx_valid_q <= 1'b1;
               if (wr_q) begin
                  ram_din_q <= {CMD_WDATA, wdata_q};
                  state_q   <= S_WDATA;
               end else begin
                  ram_din_q <= {CMD_RGO, 8'h00};
                  state_q   <= S_RCMD;
               end
            end

            S_WDATA: begin
               // Writes complete unconditionally with a clean, zero response.
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               rsp_rdata_q <= 8'h00;
               rsp_err_q   <= 1'b0;
               state_q     <= S_RESP;
            end

            S_RCMD: begin
               wait_cnt_q <= 8'h00;
               state_q    <= S_WAIT;
            end

            S_WAIT: begin
               if (ram_tx_valid) begin
                  rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                  rsp_rdata_q <= ram_dout;
                  rsp_err_q   <= 1'b0;
                  state_q     <= S_RESP;
               end else if (wait_cnt_q == LAST_WAIT) begin
                  rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                  rsp_rdata_q <= 8'h00;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end

            S_RESP: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Bench for ram_arbiter_ctrl: a transaction-level reference model checks every
// cycle, a behavioural RAM answers reads, and directed sequences pin the
// model with hand-computed values before a randomized run.
module tb_ram_arbiter_ctrl;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic [1:0]  req_ready, rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err, busy;
   logic [9:0]  ram_din;
   logic        ram_rx_valid;
   logic [7:0]  ram_dout;
   logic        ram_tx_valid;

   int vectors     = 0;
   int miscompares = 0;

   ram_arbiter_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .busy         (busy),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Arbitration rule: a lone requester wins, a tie goes to whoever was not last.
   function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // ---------------------------------------------------------------- RAM model
   // ram_mode: 0 = random read latency plus stray tx_valid pulses,
   //           1 = answers the cycle after the read-go command, 2 = never answers.
   int         ram_mode = 1;
   int         pend     = -1;
   logic [7:0] ram_mem [256];
   logic [7:0] ram_a, rd_a;

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i * 37 + 11);
      ram_tx_valid = 1'b0;
      ram_dout     = 8'h00;
      ram_a        = 8'h00;
      rd_a         = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = -1;
         end else if (ram_rx_valid) begin
            case (ram_din[9:8])
               2'b00, 2'b10: ram_a = ram_din[7:0];
               2'b01:        ram_mem[ram_a] = ram_din[7:0];
               default: begin
                  rd_a = ram_a;
                  if (ram_mode == 0)      pend = int'($urandom_range(TIMEOUT + 1, 0));
                  else if (ram_mode == 1) pend = 0;
                  else                    pend = -1;
               end
            endcase
         end
         @(posedge clk);
         #1;
         if (pend == 0) begin
            ram_tx_valid = 1'b1;
            ram_dout     = ram_mem[rd_a];
            pend         = -1;
         end else begin
            if (pend > 0) pend--;
            ram_tx_valid = (ram_mode == 0) && (pend < 0) && ($urandom_range(3, 0) == 0);
            ram_dout     = 8'($urandom);
         end
      end
   end

   // ------------------------------------------------------- reference model
   // Tracks one transaction as "k cycles since accept" and predicts every
   // output for the current cycle, then advances on the inputs of this cycle.
   bit         m_busy, m_resp, m_wr, m_own, m_err;
   bit         m_last = 1'b1;
   int         m_k;
   logic [7:0] m_addr, m_wdata, m_rdata;
   logic [7:0] m_mem [256];

   initial begin
      logic [1:0] exp_ready, exp_rspv, g;
      logic       exp_rx;
      logic [9:0] exp_din;
      int         o;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'(i * 37 + 11);
      m_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_outputs",
                32'({req_ready, rsp_valid, busy, ram_rx_valid, ram_din, rsp_rdata, rsp_err}), 32'd0);
            m_busy = 0; m_resp = 0; m_last = 1; m_rdata = 8'h00; m_err = 0;
         end else begin
            exp_ready = m_busy ? 2'b00 : rr_pick(req_valid, m_last);
            exp_rx    = m_busy && !m_resp && (m_k == 1 || m_k == 2);
            if (!exp_rx)      exp_din = 10'h000;
            else if (m_k == 1) exp_din = {(m_wr ? 2'b00 : 2'b10), m_addr};
            else if (m_wr)     exp_din = {2'b01, m_wdata};
            else               exp_din = 10'h300;
            exp_rspv = m_resp ? (m_own ? 2'b10 : 2'b01) : 2'b00;

            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("ram_cmd", 32'({ram_rx_valid, ram_din}), 32'({exp_rx, exp_din}));
            chk("rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({exp_rspv, m_err, m_rdata}));

            if (!m_busy) begin
               g = rr_pick(req_valid, m_last);
               if (g != 2'b00) begin
                  m_own   = g[1];
                  o       = int'(m_own);
                  m_wr    = req_wr[o];
                  m_addr  = req_addr[8*o +: 8];
                  m_wdata = req_wdata[8*o +: 8];
                  m_last  = m_own;
                  m_busy  = 1;
                  m_k     = 1;
               end
            end else if (m_resp) begin
               m_busy = 0;
               m_resp = 0;
            end else begin
               if (m_wr && m_k == 2) begin
                  m_mem[m_addr] = m_wdata;
                  m_rdata = 8'h00; m_err = 0; m_resp = 1;
               end else if (!m_wr && m_k >= 3) begin
                  if (ram_tx_valid) begin
                     m_rdata = m_mem[m_addr]; m_err = 0; m_resp = 1;
                  end else if (m_k - 3 == TIMEOUT - 1) begin
                     m_rdata = 8'h00; m_err = 1; m_resp = 1;
                  end
               end
               m_k++;
            end
         end
      end
   end

   // --------------------------------------------------------- directed + random
   // Present a request, wait (bounded) for it to be accepted, then scramble the
   // request inputs so any use of them after acceptance shows up.
   task automatic accept(input logic [1:0] v, input logic [1:0] wr,
                         input logic [15:0] a, input logic [15:0] d,
                         output logic [1:0] g);
      @(posedge clk); #1;
      req_valid = v; req_wr = wr; req_addr = a; req_wdata = d;
      g = 2'b00;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            g = req_ready;
            break;
         end
      end
      chk("accept_seen", 32'(g != 2'b00), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00; req_wr = ~req_wr; req_addr = ~req_addr; req_wdata = ~req_wdata;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] g;
      int         n;
      int         acc[$];
      logic [9:0] dins[$];
      logic [1:0] grants[$];

      rst = 1'b1; req_valid = 2'b00; req_wr = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
      ram_mode = 1;
      repeat (2) @(posedge clk);
      #1 req_valid = 2'b11;
      @(negedge clk);
      chk("rst_ready_held_low", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 2'b00;

      // Write req0 addr 0x3C data 0xA5.
      accept(2'b01, 2'b01, 16'h003C, 16'h00A5, g);
      chk("wr_grant", 32'(g), 32'h1);
      @(negedge clk); chk("wr_din_t1", 32'({ram_rx_valid, ram_din}), 32'h43C);
      @(negedge clk); chk("wr_din_t2", 32'({ram_rx_valid, ram_din}), 32'h5A5);
      @(negedge clk); chk("wr_rsp_t3", 32'({rsp_valid, rsp_err}), 32'h2);

      // Read req1 addr 0x3C from a one-cycle RAM.
      accept(2'b10, 2'b00, 16'h3C00, 16'h0000, g);
      chk("rd_grant", 32'(g), 32'h2);
      @(negedge clk); chk("rd_din_t1", 32'(ram_din), 32'h23C);
      @(negedge clk); chk("rd_din_t2", 32'(ram_din), 32'h300);
      @(negedge clk); chk("rd_no_rsp_t3", 32'(rsp_valid), 32'h0);
      @(negedge clk); chk("rd_rsp_t4", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h4A5);

      // Read timeout with the RAM silent.
      ram_mode = 2;
      accept(2'b01, 2'b00, 16'h0010, 16'h0000, g);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_valid == 2'b00 && n < 40);
      chk("timeout_latency", 32'(n), 32'd11);
      chk("timeout_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h300);
      @(negedge clk); chk("timeout_hold", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h100);

      // Back-to-back writes by req0.
      ram_mode = 1;
      @(posedge clk); #1;
      req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h00AA; req_wdata = 16'h00DD;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) acc.push_back(c);
         if (ram_rx_valid) dins.push_back(ram_din);
         @(posedge clk); #1;
         if (acc.size() == 1) begin req_addr = 16'h0055; req_wdata = 16'h0066; end
         if (acc.size() == 2) req_valid = 2'b00;
      end
      chk("b2b_accepts", 32'(acc.size()), 32'd2);
      chk("b2b_gap", 32'((acc.size() == 2) ? acc[1] - acc[0] : -1), 32'd4);
      chk("b2b_din_count", 32'(dins.size()), 32'd4);
      if (dins.size() == 4) begin
         chk("b2b_din0", 32'(dins[0]), 32'h0AA);
         chk("b2b_din1", 32'(dins[1]), 32'h1DD);
         chk("b2b_din2", 32'(dins[2]), 32'h055);
         chk("b2b_din3", 32'(dins[3]), 32'h166);
      end

      // Both requesters held valid from reset: grants must alternate.
      @(posedge clk); #1;
      rst = 1'b1; req_valid = 2'b11; req_wr = 2'b11; req_addr = 16'h2120; req_wdata = 16'h5A4B;
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 40 && grants.size() < 4; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) grants.push_back(req_ready);
      end
      @(posedge clk); #1 req_valid = 2'b00;
      chk("rr_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < grants.size(); i++)
         chk("rr_order", 32'(grants[i]), (i % 2 == 0) ? 32'h1 : 32'h2);

      // Reset in the middle of a read wait.
      ram_mode = 2;
      accept(2'b10, 2'b00, 16'h0700, 16'h0000, g);
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b1; req_valid = 2'b11; req_wr = 2'b00;
      #1;
      chk("midrst_drop", 32'({busy, ram_rx_valid, req_ready, rsp_valid}), 32'h0);
      @(negedge clk);
      ram_mode = 1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("midrst_req0_wins", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = 2'b00;

      // Randomized traffic with occasional resets and a variable-latency RAM.
      ram_mode = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(149, 0) == 0);
         req_valid = 2'($urandom);
         req_wr    = 2'($urandom);
         req_addr  = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
         req_wdata = 16'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 2'b00;
      repeat (20) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
